// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder with optional wait states and write-enable checking
//
// Purpose:
//   Responder end of the data SRAM port driven by EX and consumed by MEM. Holds
//   the on-chip data memory and applies byte-enable writes. Read data is
//   registered and is therefore returned the cycle after the access. An optional
//   number of wait states raises a stall request while the access is held.
//
// Ports:
//   clk              in   1   single clock, posedge
//   resetn           in   1   asynchronous active-low reset
//   data_sram_en     in   1   access request (level, held while stalled)
//   data_sram_wen    in   4   byte write enables, 4'b0000 = read
//   data_sram_addr   in   32  byte address, bits [ADDR_W+1:2] select the word
//   data_sram_wdata  in   32  write data, lane i = bits [8i+7:8i]
//   data_sram_rdata  out  32  registered read data
//   stallreq_dsram   out  1   combinational stall request
//   dsram_err        out  1   one-cycle pulse after a rejected write
//
// Configuration:
//   DSRAM_WEN_CHECK_EN - when defined, only single-byte, aligned half-word and
//   full-word enable patterns are accepted; anything else is dropped and
//   flagged on dsram_err. When undefined, every nonzero wen is applied
//   lane-wise and dsram_err is tied low.

module data_sram_resp #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_dsram,
  output logic        dsram_err
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  logic [31:0]       mem_q [DEPTH];
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx;
  logic              at_wait_end;
  logic              perform;
  logic              is_write;
  logic              wen_ok;
  logic [3:0]        lane_we;
  logic              unused_addr_bits;

  // Low address bits and everything above the word index are don't-care;
  // addresses alias modulo the memory size.
  assign idx              = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign at_wait_end = (cnt_q == WAIT_L);
  assign perform     = data_sram_en & at_wait_end;
  assign is_write    = |data_sram_wen;

  // Gated by resetn so the request is never seen as stalling while in reset.
  assign stallreq_dsram = resetn & data_sram_en & ~at_wait_end;

`ifdef DSRAM_WEN_CHECK_EN
  always_comb begin
    wen_ok = 1'b0;
    case (data_sram_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: wen_ok = 1'b1;
      default:                   wen_ok = 1'b0;
    endcase
  end
`else
  assign wen_ok = 1'b1;
`endif

  // resetn gating makes a reset that overlaps the perform edge abort the write.
  assign lane_we = (resetn && perform && wen_ok) ? data_sram_wen : 4'b0000;

  always_comb begin
    cnt_d = cnt_q;
    if (!data_sram_en) begin
      cnt_d = 4'd0;                 // flush or bubble restarts the wait count
    end else if (at_wait_end) begin
      cnt_d = 4'd0;                 // access performed this edge
    end else begin
      cnt_d = 4'(cnt_q + 4'd1);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (perform && !is_write) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory array is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;

`ifdef DSRAM_WEN_CHECK_EN
  logic err_q, err_d;

  assign err_d = perform & is_write & ~wen_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dsram_err = err_q;
`else
  assign dsram_err = 1'b0;
`endif

endmodule
